// File: rtl/dim_scaler_pkg.sv
// dim_scaler_pkg: shared FSM states and sizing helpers for dimension_scaler.
package dim_scaler_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, STORE, DONE} state_e;

    function automatic int dividend_bits(input int coord_bits, input int num_bits);
        return coord_bits + num_bits;
    endfunction

    function automatic int per_request_latency(input int channels, input int d);
        return channels * (d + 2);
    endfunction

endpackage

// File: rtl/restoring_div_core.sv
// restoring_div_core: serial restoring divider, one quotient bit per cycle, MSB first.
// A zero divisor naturally yields an all-ones quotient; the parent flags that case.
module restoring_div_core #(
    parameter int DIVIDEND_BITS = 20,
    parameter int DIVISOR_BITS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [DIVIDEND_BITS-1:0] dividend_i,
    input  logic [DIVISOR_BITS-1:0]  divisor_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [DIVIDEND_BITS-1:0] quotient_o,
    output logic [DIVISOR_BITS-1:0]  remainder_o
);

    localparam int CW = $clog2(DIVIDEND_BITS + 1);

    logic [DIVIDEND_BITS-1:0] quo_q;
    logic [DIVISOR_BITS-1:0]  rem_q;
    logic [DIVISOR_BITS-1:0]  div_q;
    logic [CW-1:0]            cnt_q;
    logic                     busy_q;
    logic [DIVISOR_BITS:0]    shift_w;
    logic [DIVISOR_BITS:0]    trial_w;
    logic                     ge_w;

    always_comb begin
        shift_w = {rem_q, quo_q[DIVIDEND_BITS-1]};
        ge_w    = shift_w >= {1'b0, div_q};
        trial_w = shift_w - {1'b0, div_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(DIVIDEND_BITS);
            quo_q  <= dividend_i;
            rem_q  <= '0;
            div_q  <= divisor_i;
        end else if (busy_q) begin
            quo_q  <= {quo_q[DIVIDEND_BITS-2:0], ge_w};
            rem_q  <= ge_w ? trial_w[DIVISOR_BITS-1:0] : shift_w[DIVISOR_BITS-1:0];
            cnt_q  <= cnt_q - CW'(1);
            busy_q <= cnt_q != CW'(1);
        end
    end

    // done marks the cycle whose closing edge completes the final iteration
    assign done_o      = busy_q && cnt_q == CW'(1);
    assign busy_o      = busy_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/dimension_scaler.sv
// dimension_scaler: y = floor((x-1)*num/den) + 1 per channel, with one shared serial divider.
module dimension_scaler
    import dim_scaler_pkg::*;
#(
    parameter int COORD_BITS = 16,
    parameter int NUM_BITS   = 4,
    parameter int DEN_BITS   = 4,
    parameter int CHANNELS   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [CHANNELS*COORD_BITS-1:0] in_dim_i,
    input  logic [NUM_BITS-1:0]            in_num_i,
    input  logic [DEN_BITS-1:0]            in_den_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [CHANNELS*COORD_BITS-1:0] out_dim_o,
    output logic [CHANNELS-1:0]            out_error_o
);

    localparam int D    = dividend_bits(COORD_BITS, NUM_BITS);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam logic [COORD_BITS-1:0] MAX = '1;

    state_e                         state_q;
    logic [CH_W-1:0]                ch_q;
    logic [CHANNELS*COORD_BITS-1:0] dim_q;
    logic [NUM_BITS-1:0]            num_q;
    logic [DEN_BITS-1:0]            den_q;
    logic [CHANNELS*COORD_BITS-1:0] out_dim_q;
    logic [CHANNELS-1:0]            out_err_q;
    logic                           out_valid_q;
    logic                           in_ready_q;

    logic [COORD_BITS-1:0] x_w;
    logic [D-1:0]          dividend_w;
    logic [D-1:0]          quo_w;
    logic                  sat_w;
    logic                  err_w;
    logic [COORD_BITS-1:0] res_w;
    logic                  div_done;
    logic                  div_busy;
    logic [DEN_BITS-1:0]   div_rem;
    logic                  unused_div;

    always_comb begin
        x_w        = dim_q[ch_q*COORD_BITS +: COORD_BITS];
        dividend_w = (x_w == '0) ? '0 : (D'(x_w) - D'(1)) * D'(num_q);
        sat_w      = quo_w >= D'(MAX);
        err_w      = den_q == '0 || sat_w;
        res_w      = (den_q == '0 || x_w == '0) ? '0 : sat_w ? MAX : quo_w[COORD_BITS-1:0] + COORD_BITS'(1);
    end

    restoring_div_core #(
        .DIVIDEND_BITS(D),
        .DIVISOR_BITS (DEN_BITS)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (state_q == LOAD),
        .dividend_i (dividend_w),
        .divisor_i  (den_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quo_w),
        .remainder_o(div_rem)
    );

    assign unused_div = ^{div_rem, div_busy};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            dim_q       <= '0;
            num_q       <= '0;
            den_q       <= '0;
            out_dim_q   <= '0;
            out_err_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush_i) begin
            state_q     <= IDLE;
            out_dim_q   <= '0;
            out_err_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i) begin
                    dim_q      <= in_dim_i;
                    num_q      <= in_num_i;
                    den_q      <= in_den_i;
                    ch_q       <= '0;
                    out_dim_q  <= '0;
                    out_err_q  <= '0;
                    in_ready_q <= 1'b0;
                    state_q    <= LOAD;
                end
                LOAD:   state_q <= DIVIDE;
                DIVIDE: if (div_done) state_q <= STORE;
                STORE: begin
                    out_dim_q[ch_q*COORD_BITS +: COORD_BITS] <= res_w;
                    out_err_q[ch_q] <= err_w;
                    if (ch_q == CH_W'(CHANNELS - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        ch_q    <= ch_q + CH_W'(1);
                        state_q <= LOAD;
                    end
                end
                DONE: if (out_ready_i) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_dim_o   = out_dim_q;
    assign out_error_o = out_err_q;

endmodule

// File: tb/tb_dimension_scaler.sv
// tb_dimension_scaler: directed checks of scaling, saturation, latency, back-pressure, flush and reset.
module tb_dimension_scaler;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_dim, out_dim;
    logic [3:0]  in_num, in_den;
    logic [1:0]  out_error;
    int          n_vec = 0;
    int          n_err = 0;
    int          lat;
    logic        seen;

    always #5 clk = ~clk;

    dimension_scaler dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_dim_i   (in_dim),
        .in_num_i   (in_num),
        .in_den_i   (in_den),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_dim_o  (out_dim),
        .out_error_o(out_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int l);
        l = 0;
        while (!out_valid && l < 200) begin
            tick();
            l++;
        end
    endtask

    task automatic req(input string tag, input logic [31:0] d, input logic [3:0] n, input logic [3:0] dn,
                       input logic [31:0] exp_dim, input logic [1:0] exp_err);
        int l;
        in_dim = d; in_num = n; in_den = dn; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, ".ready_low"}, 64'(in_ready), 64'd0);
        wait_out(l);
        chk({tag, ".latency"}, 64'(l), 64'd44);
        chk({tag, ".dim"}, 64'(out_dim), 64'(exp_dim));
        chk({tag, ".err"}, 64'(out_error), 64'(exp_err));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
        chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_dim = '0; in_num = '0; in_den = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset.ready", 64'(in_ready), 64'd1);
        chk("reset.valid", 64'(out_valid), 64'd0);
        chk("reset.dim", 64'(out_dim), 64'd0);
        chk("reset.err", 64'(out_error), 64'd0);

        req("r45", {16'd1080, 16'd1920}, 4'd4, 4'd5, {16'd864, 16'd1536}, 2'b00);
        release_out("r45");
        req("r54", {16'd864, 16'd1536}, 4'd5, 4'd4, {16'd1079, 16'd1919}, 2'b00);
        release_out("r54");
        req("sat", {16'd2, 16'd65535}, 4'd15, 4'd1, {16'd16, 16'd65535}, 2'b01);
        release_out("sat");
        req("den0", {16'd0, 16'd100}, 4'd3, 4'd0, {16'd0, 16'd0}, 2'b11);
        release_out("den0");
        req("x0", {16'd10, 16'd0}, 4'd4, 4'd5, {16'd8, 16'd0}, 2'b00);
        release_out("x0");
        req("num0", {16'd1, 16'd5}, 4'd0, 4'd3, {16'd1, 16'd1}, 2'b00);
        release_out("num0");

        // back-pressure: result held while a competing request waits on in_valid
        req("bp", {16'd1080, 16'd1920}, 4'd4, 4'd5, {16'd864, 16'd1536}, 2'b00);
        in_dim = {16'd864, 16'd1536}; in_num = 4'd5; in_den = 4'd4; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp.valid", 64'(out_valid), 64'd1);
            chk("bp.dim", 64'(out_dim), 64'({16'd864, 16'd1536}));
            chk("bp.ready", 64'(in_ready), 64'd0);
        end
        release_out("bp");
        tick();
        in_valid = 1'b0;
        chk("bp2.ready_low", 64'(in_ready), 64'd0);
        wait_out(lat);
        chk("bp2.latency", 64'(lat), 64'd44);
        chk("bp2.dim", 64'(out_dim), 64'({16'd1079, 16'd1919}));
        release_out("bp2");

        // flush twenty cycles into a request
        in_dim = {16'd1080, 16'd1920}; in_num = 4'd4; in_den = 4'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (19) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.ready", 64'(in_ready), 64'd1);
        chk("flush.valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (60) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flush.never_valid", 64'(seen), 64'd0);

        // reset while a result is held
        req("rstdone", {16'd1080, 16'd1920}, 4'd4, 4'd5, {16'd864, 16'd1536}, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstdone.valid", 64'(out_valid), 64'd0);
        chk("rstdone.dim", 64'(out_dim), 64'd0);
        chk("rstdone.err", 64'(out_error), 64'd0);
        chk("rstdone.ready", 64'(in_ready), 64'd1);

        // flush coinciding with an accept drops the request
        in_dim = {16'd1080, 16'd1920}; in_num = 4'd4; in_den = 4'd5;
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flushacc.ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (60) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flushacc.never_valid", 64'(seen), 64'd0);

        req("after", {16'd864, 16'd1536}, 4'd5, 4'd4, {16'd1079, 16'd1919}, 2'b00);
        release_out("after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
